uart_rx_fifo_ctrl: RTL and testbench
====================================

// Module: uart_rx_fifo_ctrl
// PURPOSE
// - Receive-side controller of the 16550-compatible UART. Sits between uart_rx (byte + 1-cycle o_flag strobe)
//   and the host register file. Buffers received bytes in a 16-entry FIFO.
// - Schedules the receiver interrupts: RDA (level >= trigger) and CTI (character timeout), and the overrun status.
// - Tracks the selected baud rate (i_rx_uart_bps) to time the 4-character timeout.
// PARAMETERS
// - CLK_FREQ   50_000_000  system clock, Hz; bit period table below assumes 50 MHz
// - FIFO_DEPTH 16          entries; power of two; ADDR_W = log2(FIFO_DEPTH)
// - TO_CHARS   4           character times before CTI; one char time = 10 bit times
// PORTS
// - i_sys_clk      in   1        system clock, all logic rising-edge
// - i_sys_rst      in   1        asynchronous, active-high reset
// - i_rx_data      in   8        received byte from uart_rx
// - i_rx_flag      in   1        1-cycle strobe: i_rx_data valid
// - i_rx_uart_bps  in   3        baud select, same encoding as uart_rx
// - i_fifo_en      in   1        1 = FIFO mode (16 deep), 0 = 16450 mode (1-deep holding reg)
// - i_fifo_clr     in   1        1-cycle pulse: flush FIFO
// - i_trig_lvl     in   2        RDA trigger: 0->1, 1->4, 2->8, 3->14 bytes
// - i_rd_en        in   1        1-cycle pop of oldest byte (host RBR read)
// - i_lsr_rd       in   1        1-cycle: host reads LSR, clears o_overrun
// - o_rd_data      out  8        oldest byte (first-word-fall-through); 0 when empty
// - o_level        out  ADDR_W+1 bytes stored, 0..FIFO_DEPTH
// - o_data_ready   out  1        o_level != 0
// - o_rda_irq      out  1        o_level >= trigger (trigger forced to 1 in 16450 mode)
// - o_cti_irq      out  1        character timeout pending
// - o_overrun      out  1        sticky: byte lost
// BEHAVIOUR
// - Reset: pointers, o_level, timeout counter = 0; all outputs 0.
// - Push on i_rx_flag; pop on i_rd_en; both registered, visible next cycle. Pop when empty: ignored, no error.
// - Push+pop same cycle: both performed, level unchanged (also when full or level 0: pop ignored at 0, push done).
// - Push when full, no pop (FIFO mode): byte dropped, contents kept, o_overrun <= 1.
// - 16450 mode: effective depth 1; push while level=1 without pop overwrites entry, o_overrun <= 1.
// - o_overrun: set has priority over clear when push-overflow and i_lsr_rd coincide.
// - i_fifo_clr: pointers/level -> 0, o_cti_irq -> 0, o_overrun unchanged; wins over simultaneous push/pop.
// - Toggling i_fifo_en: treated as i_fifo_clr in the same cycle.
// - Bit period (clocks @50 MHz) by bps: 0:41667 1:10417 2:5208 3:2604 4:1302 5:868 6:434 7:217.
// - Timeout counter (22 bit): cleared on push, pop, clr, bps change, or level=0; otherwise +1/cycle,
//   saturates at TO_CHARS*10*bit_period. o_cti_irq = 1 when saturated, level>0, and i_fifo_en=1.
// - o_cti_irq clears the cycle after a push or pop. o_rda_irq, o_data_ready combinational from o_level/i_trig_lvl.
// - Reset mid-operation: all state discarded immediately (asynchronous), no partial recovery.
// STRUCTURE
// - Shared include uart_defs.vh: baud bit-period table (function bps_to_period), trigger-level constants,
//   FIFO_DEPTH default; also used by uart_rx and the TX controller.
// - One sub-module: uart_sync_fifo (width 8, FWFT, depth param, full/empty/level, clr).
// - Top holds mode mux, overrun flag, timeout counter, IRQ logic.
// TESTING
// - Push 0x00..0x03 (bps=2, trig=1 i.e. 4), no reads -> o_rda_irq rises after 4th push; o_level=4; o_rd_data=0x00.
// - Push 17 bytes in FIFO mode, no reads -> o_level=16, 17th dropped, o_overrun=1; i_lsr_rd -> o_overrun=0.
// - Push 1 byte, bps=2, idle -> o_cti_irq=1 exactly 4*10*5208=208320 cycles after push; i_rd_en clears it.
// - i_fifo_en=0: push 0xA5 then 0x5A -> o_level=1, o_rd_data=0x5A, o_overrun=1, o_cti_irq never asserts.
// - Full FIFO, push+pop same cycle -> level stays 16, no overrun; i_fifo_clr with push -> level 0.
// - Assert i_sys_rst mid-stream (level=7, cti pending) -> all outputs 0 asynchronously, before next clock edge.

Source files
------------

// File: rtl/uart_rx_fifo_ctrl_pkg.sv
// Shared definitions for the UART receive-side FIFO controller.
// - Baud-select to bit-period table (clocks per bit at a 50 MHz system clock).
// - RDA trigger-level constants and the trigger decode helper.
// - Default FIFO depth and character-timeout parameters.
package uart_rx_fifo_ctrl_pkg;

  // The bit-period table below is only valid for this system clock.
  localparam int CLK_FREQ        = 50_000_000;
  localparam int DEF_FIFO_DEPTH  = 16;
  localparam int DEF_TO_CHARS    = 4;
  localparam int BITS_PER_CHAR   = 10;
  localparam int TO_W            = 22;

  localparam int TRIG_BYTES_0 = 1;
  localparam int TRIG_BYTES_1 = 4;
  localparam int TRIG_BYTES_2 = 8;
  localparam int TRIG_BYTES_3 = 14;

  // Clocks per bit for each baud select (same encoding as uart_rx).
  function automatic logic [15:0] bps_to_period(input logic [2:0] bps);
    case (bps)
      3'd0:    return 16'd41667;
      3'd1:    return 16'd10417;
      3'd2:    return 16'd5208;
      3'd3:    return 16'd2604;
      3'd4:    return 16'd1302;
      3'd5:    return 16'd868;
      3'd6:    return 16'd434;
      default: return 16'd217;
    endcase
  endfunction

  // RDA trigger field to byte count.
  function automatic int trig_to_bytes(input logic [1:0] trig);
    case (trig)
      2'd0:    return TRIG_BYTES_0;
      2'd1:    return TRIG_BYTES_1;
      2'd2:    return TRIG_BYTES_2;
      default: return TRIG_BYTES_3;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clr             flush: pointers and level to 0, wins over push/pop
//   push, din       write din this cycle (dropped when full unless popping)
//   pop             discard oldest entry this cycle (ignored when empty)
//   dout            oldest entry, 0 when empty
//   level           entries stored, 0..DEPTH
//   full, empty     level == DEPTH / level == 0
module uart_sync_fifo
  import uart_rx_fifo_ctrl_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = DEF_FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              push_ok, pop_ok;

  always_comb begin
    empty   = (level_q == '0);
    full    = (level_q == (ADDR_W+1)'(DEPTH));
    pop_ok  = pop & ~empty;
    // A push into a full FIFO still succeeds when the same cycle frees a slot.
    push_ok = push & (~full | pop_ok);
    dout    = empty ? '0 : mem_q[rd_ptr_q];
    level   = level_q;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + (ADDR_W+1)'(1);
        2'b01:   level_d = level_q - (ADDR_W+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: dout is masked to 0 while empty.
  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// Receive-side controller of a 16550-compatible UART.
// Buffers bytes from uart_rx in a FIFO (or a 1-deep holding register in
// 16450 mode), and generates RDA, character-timeout (CTI) and overrun status.
// Ports:
//   i_sys_clk, i_sys_rst   clock, asynchronous active-high reset
//   i_rx_data, i_rx_flag   received byte and its 1-cycle valid strobe
//   i_rx_uart_bps          baud select, times the character timeout
//   i_fifo_en              1 = FIFO mode, 0 = 16450 mode; a change flushes
//   i_fifo_clr             1-cycle flush pulse
//   i_trig_lvl             RDA trigger: 1/4/8/14 bytes
//   i_rd_en                1-cycle pop of the oldest byte
//   i_lsr_rd               1-cycle LSR read, clears o_overrun
//   o_rd_data              oldest byte (fall-through), 0 when empty
//   o_level                bytes stored
//   o_data_ready           o_level != 0
//   o_rda_irq              o_level >= trigger
//   o_cti_irq              character timeout pending
//   o_overrun              sticky byte-lost flag
//
// Strobe semantics: i_rx_flag, i_rd_en, i_fifo_clr and i_lsr_rd are
// single-cycle requests with no back-pressure; each is acted on at the
// rising edge where it is high and the effect is visible after that edge.
// A pop of an empty buffer and a push into a full one are silently absorbed
// (the latter raising o_overrun).
module uart_rx_fifo_ctrl
  import uart_rx_fifo_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TO_CHARS   = DEF_TO_CHARS,
  localparam int ADDR_W    = $clog2(FIFO_DEPTH),
  localparam int LW        = ADDR_W + 1
) (
  input  logic          i_sys_clk,
  input  logic          i_sys_rst,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_flag,
  input  logic [2:0]    i_rx_uart_bps,
  input  logic          i_fifo_en,
  input  logic          i_fifo_clr,
  input  logic [1:0]    i_trig_lvl,
  input  logic          i_rd_en,
  input  logic          i_lsr_rd,
  output logic [7:0]    o_rd_data,
  output logic [LW-1:0] o_level,
  output logic          o_data_ready,
  output logic          o_rda_irq,
  output logic          o_cti_irq,
  output logic          o_overrun
);

  logic            fifo_en_q, fifo_en_d;
  logic [2:0]      bps_q, bps_d;
  logic            overrun_q, overrun_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  logic [LW-1:0]   level;
  logic            full, empty;
  logic            flush, fifo_pop, overflow;
  logic            to_clr, to_sat;
  logic [TO_W-1:0] to_limit;
  logic [LW-1:0]   trig_bytes;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_sys_clk),
    .rst   (i_sys_rst),
    .clr   (flush),
    .push  (i_rx_flag),
    .pop   (fifo_pop),
    .din   (i_rx_data),
    .dout  (o_rd_data),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    // A mode change discards whatever was buffered under the old mode.
    flush    = i_fifo_clr | (i_fifo_en ^ fifo_en_q);
    // 16450 overwrite: a push onto the held byte also pops it, so the new
    // byte replaces the old one and the level stays at 1.
    fifo_pop = i_rd_en | (~i_fifo_en & i_rx_flag & ~empty);
    overflow = i_rx_flag & ~i_rd_en & ~flush & (i_fifo_en ? full : ~empty);

    to_limit = TO_W'(TO_CHARS * BITS_PER_CHAR) * TO_W'(bps_to_period(i_rx_uart_bps));
    to_sat   = (to_cnt_q == to_limit);
    to_clr   = i_rx_flag | i_rd_en | flush | (i_rx_uart_bps != bps_q) | empty;

    trig_bytes = i_fifo_en ? LW'(trig_to_bytes(i_trig_lvl)) : LW'(1);

    fifo_en_d = i_fifo_en;
    bps_d     = i_rx_uart_bps;

    // Set wins over an LSR read in the same cycle so the loss is not missed.
    overrun_d = overrun_q;
    if (overflow)      overrun_d = 1'b1;
    else if (i_lsr_rd) overrun_d = 1'b0;

    if (to_clr)      to_cnt_d = '0;
    else if (to_sat) to_cnt_d = to_cnt_q;
    else             to_cnt_d = to_cnt_q + TO_W'(1);
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      fifo_en_q <= 1'b0;
      bps_q     <= '0;
      overrun_q <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      fifo_en_q <= fifo_en_d;
      bps_q     <= bps_d;
      overrun_q <= overrun_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign o_level      = level;
  assign o_data_ready = ~empty;
  assign o_rda_irq    = (level >= trig_bytes);
  assign o_cti_irq    = to_sat & ~empty & i_fifo_en;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
module tb_uart_rx_fifo_ctrl;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_flag = 1'b0;
  logic [2:0] bps = 3'd7;
  logic       fifo_en = 1'b1;
  logic       fifo_clr = 1'b0;
  logic [1:0] trig = 2'd1;
  logic       rd_en = 1'b0;
  logic       lsr_rd = 1'b0;

  logic [7:0] o_rd_data;
  logic [4:0] o_level;
  logic       o_data_ready, o_rda_irq, o_cti_irq, o_overrun;

  always #5 clk = ~clk;

  // Character timeout at bps=7: 4 chars * 10 bits * 217 clocks.
  localparam int LIM7 = 8680;

  uart_rx_fifo_ctrl dut (
    .i_sys_clk     (clk),
    .i_sys_rst     (rst),
    .i_rx_data     (rx_data),
    .i_rx_flag     (rx_flag),
    .i_rx_uart_bps (bps),
    .i_fifo_en     (fifo_en),
    .i_fifo_clr    (fifo_clr),
    .i_trig_lvl    (trig),
    .i_rd_en       (rd_en),
    .i_lsr_rd      (lsr_rd),
    .o_rd_data     (o_rd_data),
    .o_level       (o_level),
    .o_data_ready  (o_data_ready),
    .o_rda_irq     (o_rda_irq),
    .o_cti_irq     (o_cti_irq),
    .o_overrun     (o_overrun)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic push, input logic [7:0] d, input logic pop,
                      input logic lsr, input logic clr);
    rx_flag  = push;
    rx_data  = d;
    rd_en    = pop;
    lsr_rd   = lsr;
    fifo_clr = clr;
    tick();
    rx_flag  = 1'b0;
    rd_en    = 1'b0;
    lsr_rd   = 1'b0;
    fifo_clr = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       push;
    logic [7:0] din;
    logic       pop;
    logic       lsr;
    logic       clr;
    logic [1:0] trig;
    logic [4:0] level;
    logic       rda;
    logic       ovr;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       cti_seen;

    //            push  din    pop   lsr   clr   trig  level  rda   ovr   dout
    vecs[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 5'd1, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 2'd1, 5'd2, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 2'd1, 5'd3, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 2'd1, 5'd4, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd1, 5'd3, 1'b0, 1'b0, 8'h01};
    vecs[5]  = '{1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 2'd1, 5'd3, 1'b0, 1'b0, 8'h02};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd1, 5'd2, 1'b0, 1'b0, 8'h03};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd1, 5'd1, 1'b0, 1'b0, 8'h04};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd1, 5'd0, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd1, 5'd0, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 2'd1, 5'd1, 1'b0, 1'b0, 8'h77};
    vecs[11] = '{1'b1, 8'h88, 1'b0, 1'b0, 1'b1, 2'd1, 5'd0, 1'b0, 1'b0, 8'h00};
    vecs[12] = '{1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 2'd0, 5'd1, 1'b1, 1'b0, 8'h99};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd3, 5'd1, 1'b0, 1'b0, 8'h99};

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    chk("reset_level", 32'(o_level), 32'd0);
    chk("reset_ready", 32'(o_data_ready), 32'd0);
    chk("reset_rda", 32'(o_rda_irq), 32'd0);
    chk("reset_cti", 32'(o_cti_irq), 32'd0);
    chk("reset_ovr", 32'(o_overrun), 32'd0);
    chk("reset_data", 32'(o_rd_data), 32'd0);
    rst = 1'b0;
    tick();
    tick();

    // ---- table-driven vectors ----
    for (int i = 0; i < 14; i++) begin
      trig = vecs[i].trig;
      step(vecs[i].push, vecs[i].din, vecs[i].pop, vecs[i].lsr, vecs[i].clr);
      chk($sformatf("vec%0d_level", i), 32'(o_level), 32'(vecs[i].level));
      chk($sformatf("vec%0d_ready", i), 32'(o_data_ready), 32'(vecs[i].level != 5'd0));
      chk($sformatf("vec%0d_rda", i), 32'(o_rda_irq), 32'(vecs[i].rda));
      chk($sformatf("vec%0d_ovr", i), 32'(o_overrun), 32'(vecs[i].ovr));
      chk($sformatf("vec%0d_data", i), 32'(o_rd_data), 32'(vecs[i].dout));
    end
    trig = 2'd1;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("flush_level", 32'(o_level), 32'd0);

    // ---- overflow, push+pop at full, overrun priority, drain ----
    exp_q.delete();
    exp_ovr = 1'b0;
    for (int i = 0; i < 17; i++) begin
      d = 8'($urandom_range(0, 255));
      step(1'b1, d, 1'b0, 1'b0, 1'b0);
      if (exp_q.size() < 16) exp_q.push_back(d);
      else exp_ovr = 1'b1;
    end
    chk("ovf_level", 32'(o_level), 32'(exp_q.size()));
    chk("ovf_overrun", 32'(o_overrun), 32'(exp_ovr));
    chk("ovf_rda", 32'(o_rda_irq), 32'd1);
    chk("ovf_head", 32'(o_rd_data), 32'(exp_q[0]));
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("lsr_clears_ovr", 32'(o_overrun), 32'd0);

    d = 8'hC3;
    step(1'b1, d, 1'b1, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    exp_q.push_back(d);
    chk("full_pushpop_level", 32'(o_level), 32'd16);
    chk("full_pushpop_ovr", 32'(o_overrun), 32'd0);
    chk("full_pushpop_head", 32'(o_rd_data), 32'(exp_q[0]));

    step(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
    chk("ovr_set_beats_clear", 32'(o_overrun), 32'd1);
    chk("ovr_drop_level", 32'(o_level), 32'd16);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("ovr_cleared_again", 32'(o_overrun), 32'd0);

    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d", i), 32'(o_rd_data), 32'(exp_q.pop_front()));
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("drain_level", 32'(o_level), 32'd0);
    chk("drain_data", 32'(o_rd_data), 32'd0);
    chk("drain_ready", 32'(o_data_ready), 32'd0);

    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    chk("refill_level", 32'(o_level), 32'd16);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    chk("clr_beats_push_level", 32'(o_level), 32'd0);
    chk("clr_keeps_ovr", 32'(o_overrun), 32'd0);

    // ---- character timeout at bps=7 ----
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    repeat (LIM7 - 1) tick();
    chk("cti_before_limit", 32'(o_cti_irq), 32'd0);
    tick();
    chk("cti_at_limit", 32'(o_cti_irq), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("cti_cleared_by_pop", 32'(o_cti_irq), 32'd0);
    chk("cti_pop_level", 32'(o_level), 32'd1);
    repeat (4000) tick();
    bps = 3'd6;
    tick();
    bps = 3'd7;
    tick();
    repeat (LIM7 - 1) tick();
    chk("cti_bps_restart_before", 32'(o_cti_irq), 32'd0);
    tick();
    chk("cti_bps_restart_at", 32'(o_cti_irq), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("cti_cleared_by_clr", 32'(o_cti_irq), 32'd0);
    chk("cti_clr_level", 32'(o_level), 32'd0);

    // ---- 16450 mode ----
    fifo_en = 1'b0;
    trig = 2'd3;
    tick();
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("m16450_first_level", 32'(o_level), 32'd1);
    chk("m16450_first_data", 32'(o_rd_data), 32'hA5);
    chk("m16450_first_ovr", 32'(o_overrun), 32'd0);
    chk("m16450_rda_trig1", 32'(o_rda_irq), 32'd1);
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    chk("m16450_over_level", 32'(o_level), 32'd1);
    chk("m16450_over_data", 32'(o_rd_data), 32'h5A);
    chk("m16450_over_ovr", 32'(o_overrun), 32'd1);
    cti_seen = 1'b0;
    for (int i = 0; i < LIM7 + 300; i++) begin
      tick();
      if (o_cti_irq) cti_seen = 1'b1;
    end
    chk("m16450_no_cti", 32'(cti_seen), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("m16450_pop_level", 32'(o_level), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("m16450_lsr_ovr", 32'(o_overrun), 32'd0);
    fifo_en = 1'b1;
    trig = 2'd1;
    tick();

    // ---- asynchronous reset mid-stream ----
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    repeat (LIM7) tick();
    chk("pre_rst_level", 32'(o_level), 32'd7);
    chk("pre_rst_cti", 32'(o_cti_irq), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_level", 32'(o_level), 32'd0);
    chk("async_rst_ready", 32'(o_data_ready), 32'd0);
    chk("async_rst_rda", 32'(o_rda_irq), 32'd0);
    chk("async_rst_cti", 32'(o_cti_irq), 32'd0);
    chk("async_rst_ovr", 32'(o_overrun), 32'd0);
    chk("async_rst_data", 32'(o_rd_data), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_level", 32'(o_level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
